// File: rtl/microram_ctl.sv
// Single-port synchronous RAM controller: REQ/READY access, registered read with VALID strobe,
// post-reset clear sequencer and sticky out-of-range error flag.
module microram_ctl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 9,
  parameter int                    DEPTH          = 512,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] DATAIN,
  output logic [DATA_WIDTH-1:0] DATAOUT,
  output logic                  VALID,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  ERR,
  output logic                  state_dbg
);

  // Handshake: an access is accepted on a rising edge where REQ and READY are both high;
  // a read answers with VALID high for exactly the following cycle, writes never raise VALID.

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    in_range;
  logic                    accept;
  logic [IDX_W-1:0]        acc_idx;
  logic [IDX_W-1:0]        clr_idx;

  // Full-width compare so depths below 2**ADDR_WIDTH are still caught.
  assign in_range  = ({1'b0, ADDRESS} < DEPTH_EXT);
  assign accept    = REQ & (state == ST_RUN);
  assign acc_idx   = ADDRESS[IDX_W-1:0];
  assign clr_idx   = clr_cnt[IDX_W-1:0];

  assign READY     = (state == ST_RUN);
  assign BUSY      = (state == ST_CLEAR);
  assign state_dbg = logic'(state);

  // Storage array; RESET does not touch contents, it only suppresses writes on its own edge.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      if (state == ST_CLEAR) begin
        mem[clr_idx] <= CLEAR_VALUE;
      end else if (accept && WE && in_range) begin
        mem[acc_idx] <= DATAIN;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      DATAOUT <= '0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
      clr_cnt <= '0;
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      VALID <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= ST_RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (REQ) begin
            if (!in_range) begin
              ERR <= 1'b1;
            end
            if (!WE) begin
              VALID   <= 1'b1;
              DATAOUT <= in_range ? mem[acc_idx] : CLEAR_VALUE;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_microram_ctl.sv
// Bench for microram_ctl: three configurations share one request bus and are checked every cycle
// against a per-instance behavioural model, plus directed checks against fixed constants.
module tb_microram_ctl;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic       req, we;
  logic [8:0] addr;
  logic [7:0] din;

  logic [7:0] dout  [3];
  logic       valid [3];
  logic       ready [3];
  logic       busy  [3];
  logic       err   [3];
  logic       sdbg  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  microram_ctl u0 (
    .CLOCK(clk), .RESET(rst[0]), .REQ(req), .WE(we), .ADDRESS(addr), .DATAIN(din),
    .DATAOUT(dout[0]), .VALID(valid[0]), .READY(ready[0]), .BUSY(busy[0]), .ERR(err[0]),
    .state_dbg(sdbg[0])
  );

  microram_ctl #(.DEPTH(300), .CLEAR_VALUE(8'hFF)) u1 (
    .CLOCK(clk), .RESET(rst[1]), .REQ(req), .WE(we), .ADDRESS(addr), .DATAIN(din),
    .DATAOUT(dout[1]), .VALID(valid[1]), .READY(ready[1]), .BUSY(busy[1]), .ERR(err[1]),
    .state_dbg(sdbg[1])
  );

  microram_ctl #(.CLEAR_ON_RESET(1'b0)) u2 (
    .CLOCK(clk), .RESET(rst[2]), .REQ(req), .WE(we), .ADDRESS(addr), .DATAIN(din),
    .DATAOUT(dout[2]), .VALID(valid[2]), .READY(ready[2]), .BUSY(busy[2]), .ERR(err[2]),
    .state_dbg(sdbg[2])
  );

  // Reference model: remaining clear cycles per instance and a word array with known flags.
  int         dep [3] = '{512, 300, 512};
  logic [7:0] cvs [3] = '{8'h00, 8'hFF, 8'h00};
  bit         cor [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] mm  [3][512];
  bit         kn  [3][512];
  int         rem [3];
  logic [7:0] e_dout  [3];
  bit         e_dk    [3];
  logic       e_valid [3];
  logic       e_err   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int a;
    a = int'(addr);
    e_valid[i] = 1'b0;
    if (rst[i]) begin
      e_dout[i] = 8'h00;
      e_dk[i]   = 1'b1;
      e_err[i]  = 1'b0;
      rem[i]    = cor[i] ? dep[i] : 0;
    end else if (rem[i] > 0) begin
      mm[i][dep[i] - rem[i]] = cvs[i];
      kn[i][dep[i] - rem[i]] = 1'b1;
      rem[i]--;
    end else if (req) begin
      if (a >= dep[i]) begin
        e_err[i] = 1'b1;
        if (!we) begin
          e_valid[i] = 1'b1;
          e_dout[i]  = cvs[i];
          e_dk[i]    = 1'b1;
        end
      end else if (we) begin
        mm[i][a] = din;
        kn[i][a] = 1'b1;
      end else begin
        e_valid[i] = 1'b1;
        e_dout[i]  = mm[i][a];
        e_dk[i]    = kn[i][a];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_ready", i), 32'(ready[i]), 32'(rem[i] == 0));
      chk($sformatf("u%0d_busy", i),  32'(busy[i]),  32'(rem[i] > 0));
      chk($sformatf("u%0d_valid", i), 32'(valid[i]), 32'(e_valid[i]));
      chk($sformatf("u%0d_err", i),   32'(err[i]),   32'(e_err[i]));
      if (e_dk[i]) chk($sformatf("u%0d_dout", i), 32'(dout[i]), 32'(e_dout[i]));
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [8:0] a, input logic [7:0] d);
    req  = r;
    we   = w;
    addr = a;
    din  = d;
  endtask

  task automatic drive_rand(input logic force_write);
    drive(1'($urandom_range(0, 1)) | force_write, force_write | 1'($urandom_range(0, 1)),
          9'($urandom_range(0, 511)), 8'($urandom));
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; e_dk[i] = 1'b0; e_valid[i] = 1'b0; e_err[i] = 1'b0; e_dout[i] = 8'h00;
      for (int j = 0; j < 512; j++) kn[i][j] = 1'b0;
    end
    drive(1'b0, 1'b0, 9'd0, 8'd0);
    rst = 3'b111;
    tick();
    chk("rst_busy_u0", 32'(busy[0]), 32'd1);
    chk("rst_ready_u2", 32'(ready[2]), 32'd1);
    chk("rst_dout_u0", 32'(dout[0]), 32'd0);
    rst = 3'b000;

    // Full clear with random traffic on the bus; only instances in RUN may act on it.
    cnt = 0;
    while (busy[0] && cnt < 600) begin
      drive_rand(1'b0);
      tick();
      cnt++;
    end
    chk("clear_len", 32'(cnt), 32'd512);

    drive(1'b1, 1'b0, 9'd0, 8'd0);   tick();
    chk("rd0_dout", 32'(dout[0]), 32'h00);   chk("rd0_valid", 32'(valid[0]), 32'd1);
    drive(1'b1, 1'b0, 9'd255, 8'd0); tick();
    chk("rd255_dout", 32'(dout[0]), 32'h00); chk("rd255_valid", 32'(valid[0]), 32'd1);
    drive(1'b1, 1'b0, 9'd511, 8'd0); tick();
    chk("rd511_dout", 32'(dout[0]), 32'h00); chk("rd511_valid", 32'(valid[0]), 32'd1);

    drive(1'b1, 1'b1, 9'h012, 8'hA5); tick();
    chk("wr_valid_low", 32'(valid[0]), 32'd0);
    drive(1'b1, 1'b0, 9'h012, 8'h00); tick();
    chk("rd_a5_dout", 32'(dout[0]), 32'hA5); chk("rd_a5_valid", 32'(valid[0]), 32'd1);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 9'(i), 8'(i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 9'(i), 8'h00);
      tick();
      chk($sformatf("stream_dout_%0d", i), 32'(dout[0]), 32'(i));
      chk($sformatf("stream_valid_%0d", i), 32'(valid[0]), 32'd1);
    end
    drive(1'b0, 1'b0, 9'd0, 8'h00); tick();
    chk("idle_valid", 32'(valid[0]), 32'd0);
    chk("idle_hold", 32'(dout[0]), 32'd7);

    drive(1'b1, 1'b1, 9'd300, 8'h77); tick();
    chk("oor_wr_err", 32'(err[1]), 32'd1);
    chk("inrange_err_u0", 32'(err[0]), 32'd0);
    drive(1'b1, 1'b0, 9'd400, 8'h00); tick();
    chk("oor_rd_dout", 32'(dout[1]), 32'hFF);
    chk("oor_rd_valid", 32'(valid[1]), 32'd1);

    repeat (300) begin
      drive_rand(1'b0);
      tick();
    end
    chk("err_sticky", 32'(err[1]), 32'd1);

    // Reset everything, then reset u0 again 100 cycles into its clear while writes are offered.
    drive(1'b0, 1'b0, 9'd0, 8'h00);
    rst = 3'b111; tick();
    chk("err_cleared", 32'(err[1]), 32'd0);
    chk("cor0_ready", 32'(ready[2]), 32'd1);
    rst = 3'b000;
    repeat (100) begin
      drive_rand(1'b1);
      tick();
    end
    rst = 3'b001; tick();
    rst = 3'b000;
    cnt = 0;
    while (busy[0] && cnt < 600) begin
      drive_rand(1'b1);
      tick();
      cnt++;
    end
    chk("restart_clear_len", 32'(cnt), 32'd512);

    for (int a = 0; a < 512; a++) begin
      drive(1'b1, 1'b0, 9'(a), 8'h00);
      tick();
      chk($sformatf("sweep_%0d", a), 32'(dout[0]), 32'h00);
    end

    drive(1'b1, 1'b1, 9'd5, 8'h3C); tick();
    drive(1'b0, 1'b0, 9'd0, 8'h00);
    rst = 3'b100; tick();
    chk("cor0_ready_after_rst", 32'(ready[2]), 32'd1);
    chk("cor0_busy", 32'(busy[2]), 32'd0);
    rst = 3'b000;
    drive(1'b1, 1'b0, 9'd5, 8'h00); tick();
    chk("cor0_survive", 32'(dout[2]), 32'h3C);
    drive(1'b0, 1'b0, 9'd0, 8'h00); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microram_ctl.md
# microram_ctl

Parametrised single-port synchronous RAM controller: the next generation of the team's fixed 512x8 program/data RAM. Width and depth are parametrised. A REQ/READY access handshake is added, with a registered read and a VALID strobe. A hardware clear sequencer fills the array with a known value after reset, and a sticky flag catches out-of-range addresses. It sits between the microcontroller core's memory port and the storage array.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 9, address bus width
- DEPTH, 512, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- CLEAR_VALUE, 0, word written by the clear sequencer and returned on out-of-range reads (DATA_WIDTH bits)
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to RUN

- CLOCK  in  1  single clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  access request, sampled on CLOCK
- WE  in  1  1 = write, 0 = read; qualified by REQ
- ADDRESS  in  ADDR_WIDTH  word address
- DATAIN  in  DATA_WIDTH  write data
- DATAOUT  out  DATA_WIDTH  registered read data
- VALID  out  1  one-cycle strobe: DATAOUT holds new read data
- READY  out  1  high in RUN state; requests are accepted only when high
- BUSY  out  1  high while the clear sequence runs
- ERR  out  1  sticky: an accepted access used ADDRESS >= DEPTH

## Operation
- States: CLEAR, RUN. READY = (state == RUN). BUSY = (state == CLEAR). Both outputs are decoded from the state register.
- RESET sampled high:
  - DATAOUT <= 0, VALID <= 0, ERR <= 0, clear counter <= 0.
  - State <= CLEAR if CLEAR_ON_RESET, else RUN.
  - Array contents are not touched by RESET itself.
- CLEAR: each cycle with RESET low, mem[counter] <= CLEAR_VALUE and the counter increments. On the cycle that writes DEPTH-1, state <= RUN and the counter returns to 0.
- Requests while in CLEAR are ignored: no write, no VALID, ERR unchanged.
- Accepted access = REQ & READY at a rising edge.
- Read, ADDRESS < DEPTH: DATAOUT <= mem[ADDRESS], VALID <= 1.
- Read, ADDRESS >= DEPTH: DATAOUT <= CLEAR_VALUE, VALID <= 1, ERR <= 1.
- Write, ADDRESS < DEPTH: mem[ADDRESS] <= DATAIN. DATAOUT holds its value, VALID <= 0.
- Write, ADDRESS >= DEPTH: array untouched, ERR <= 1, VALID <= 0.
- No accepted read: VALID <= 0, DATAOUT holds its last value.
- Read of an address written on the previous edge returns the new data. A read and a write cannot occur on the same edge because the port is single.
- ERR is cleared only by RESET.

## Timing
- Read latency is 1: a read accepted at edge k gives DATAOUT/VALID valid from edge k until edge k+1.
- Back-to-back reads give one word per cycle. VALID stays high continuously across consecutive reads.
- Write takes effect at the accepting edge and is readable from the next request.
- Clear duration: with RESET deasserted before edge 1, edges 1..DEPTH write addresses 0..DEPTH-1, and READY rises after edge DEPTH.
- With CLEAR_ON_RESET=0, READY is high after the first edge at which RESET is sampled high.
- RESET high mid-clear restarts the counter at 0, and a full DEPTH-cycle clear follows.
- RESET high in RUN aborts any pending VALID: VALID is 0 after that edge.
- REQ held high through CLEAR is first accepted on the first edge with READY high.
- Out-of-range detection compares the full ADDRESS against DEPTH, so it also applies when DEPTH < 2**ADDR_WIDTH.

## Test plan
- Defaults; RESET one cycle, then low: BUSY=1, READY=0 for exactly 512 cycles, then READY=1. Reads of addresses 0, 255 and 511 return 0x00 with VALID=1 one cycle after acceptance.
- Write 0xA5 to address 0x012, then read 0x012 on the next cycle: DATAOUT=0xA5 and VALID=1 one cycle after the read edge. A write-only cycle has VALID=0.
- Streaming reads of addresses 0..7 after writing data = address: DATAOUT sequence 0..7 on consecutive cycles, with VALID high for 8 consecutive cycles.
- DEPTH=300, ADDR_WIDTH=9, CLEAR_VALUE=0xFF:
  - Write to address 300 leaves the array unchanged and sets ERR=1.
  - Read of address 400 returns 0xFF with VALID=1.
  - ERR stays 1 until RESET.
- RESET asserted at clear cycle 100: BUSY stays 1 for 512 more cycles after deassertion. REQ writes issued during BUSY are not stored (verified by reads after READY).
- CLEAR_ON_RESET=0:
  - Pre-written data survives RESET: write 0x3C to address 5, RESET, then read address 5 returns 0x3C.
  - READY=1 after the first edge at which RESET is sampled high.
  - BUSY never asserts.
